instr_encoder_loader: RTL and testbench

//   Inverse of imm_gen: packs RISC-V fields (opcode, rd, rs1, rs2, funct3, funct7, 12-bit imm) into a
//   32-bit instruction word. Writes encoded words to sequential instruction-memory addresses through a
//   one-deep registered stage. Used by benches and boot logic to preload imem so that decoding each

---
 rtl/rv_isa_pkg.sv | 24 ++
 rtl/instr_pack.sv | 31 +++
 rtl/instr_encoder_loader.sv | 124 ++++++++++++
 tb/tb_instr_encoder_loader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_isa_pkg.sv
// Shared RISC-V encoding constants and the loader state type used by the
// instruction encoder/loader and its field packer.
package rv_isa_pkg;

  localparam int OPC_W   = 7;
  localparam int REG_W   = 5;
  localparam int F3_W    = 3;
  localparam int F7_W    = 7;
  localparam int IMM_W   = 12;
  localparam int INSTR_W = 32;

  localparam logic [OPC_W-1:0] OP_R    = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_I    = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_LOAD = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_S    = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_SB   = 7'b1100011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_PEND  = 2'd1,
    ST_FULL  = 2'd2
  } load_state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: assembles a 32-bit RISC-V word from its fields and
// flags whether the opcode is one of the supported layouts.
module instr_pack
  import rv_isa_pkg::*;
(
  input  logic [OPC_W-1:0]   opcode_i,
  input  logic [REG_W-1:0]   rd_i,
  input  logic [REG_W-1:0]   rs1_i,
  input  logic [REG_W-1:0]   rs2_i,
  input  logic [F3_W-1:0]    funct3_i,
  input  logic [F7_W-1:0]    funct7_i,
  input  logic [IMM_W-1:0]   imm_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic               legal_o
);

  // SB immediates arrive as imm[12:1], so imm_i[11] is branch bit 12 and imm_i[10] is bit 11.
  always_comb begin
    instr_o = '0;
    legal_o = 1'b1;
    unique case (opcode_i)
      OP_R:          instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      OP_I, OP_LOAD: instr_o = {imm_i, rs1_i, funct3_i, rd_i, opcode_i};
      OP_S:          instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      OP_SB:         instr_o = {imm_i[11], imm_i[9:4], rs2_i, rs1_i, funct3_i,
                                imm_i[3:0], imm_i[10], opcode_i};
      default:       legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes field bundles into instruction words and streams them to sequential
// imem addresses through a one-deep output register, stopping after DEPTH words.
module instr_encoder_loader
  import rv_isa_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [OPC_W-1:0]   opcode_i,
  input  logic [REG_W-1:0]   rd_i,
  input  logic [REG_W-1:0]   rs1_i,
  input  logic [REG_W-1:0]   rs2_i,
  input  logic [F3_W-1:0]    funct3_i,
  input  logic [F7_W-1:0]    funct7_i,
  input  logic [IMM_W-1:0]   imm_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [ADDR_W-1:0]  out_addr_o,
  output logic [INSTR_W-1:0] out_instr_o,
  output logic               full_o,
  output logic               err_illegal_o
);

  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  load_state_e        state_q, state_d;
  logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               err_q, err_d;

  logic [INSTR_W-1:0] packed_instr;
  logic               legal;
  logic               at_depth;
  logic               accept;
  logic               load;
  logic               xfer;

  instr_pack u_pack (
    .opcode_i (opcode_i),
    .rd_i     (rd_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .funct3_i (funct3_i),
    .funct7_i (funct7_i),
    .imm_i    (imm_i),
    .instr_o  (packed_instr),
    .legal_o  (legal)
  );

  assign at_depth   = (wr_ptr_q == DEPTH_P);
  assign in_ready_o = !at_depth &&
                      ((state_q == ST_EMPTY) || ((state_q == ST_PEND) && out_ready_i));
  assign accept     = in_valid_i && in_ready_o;
  assign load       = accept && legal;
  assign xfer       = (state_q == ST_PEND) && out_ready_i;

  // A transfer and a fresh load in the same cycle keep PEND busy with no bubble.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    addr_d   = addr_q;
    instr_d  = instr_q;
    err_d    = err_q;

    if (accept && !legal) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      ST_EMPTY: if (load) state_d = ST_PEND;
      ST_PEND: begin
        if (xfer) begin
          if (load)          state_d = ST_PEND;
          else if (at_depth) state_d = ST_FULL;
          else               state_d = ST_EMPTY;
        end
      end
      ST_FULL: state_d = ST_FULL;
      default: state_d = ST_EMPTY;
    endcase

    if (load) begin
      instr_d  = packed_instr;
      addr_d   = wr_ptr_q[ADDR_W-1:0];
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (clear_i) begin
      state_d  = ST_EMPTY;
      wr_ptr_d = '0;
      err_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      wr_ptr_q <= '0;
      addr_q   <= '0;
      instr_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      addr_q   <= addr_d;
      instr_q  <= instr_d;
      err_q    <= err_d;
    end
  end

  assign out_valid_o   = (state_q == ST_PEND);
  assign out_addr_o    = addr_q;
  assign out_instr_o   = instr_q;
  assign full_o        = (state_q == ST_FULL);
  assign err_illegal_o = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader (DEPTH=4): a vector table of field
// bundles with hand-encoded words, plus sequences for full, stall, illegal and reset.
module tb_instr_encoder_loader;

  typedef struct {
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm;
    logic [31:0] expWord;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        inValid;
  logic        inReady;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] imm;
  logic        outValid;
  logic        outReady;
  logic [4:0]  outAddr;
  logic [31:0] outInstr;
  logic        full;
  logic        errIllegal;

  int   nTests;
  int   nFail;
  int   nWrites;
  vec_t vecs[10];
  vec_t illegalVec;

  instr_encoder_loader #(.ADDR_W(5), .DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear_i       (clear),
    .in_valid_i    (inValid),
    .in_ready_o    (inReady),
    .opcode_i      (opcode),
    .rd_i          (rd),
    .rs1_i         (rs1),
    .rs2_i         (rs2),
    .funct3_i      (funct3),
    .funct7_i      (funct7),
    .imm_i         (imm),
    .out_valid_o   (outValid),
    .out_ready_i   (outReady),
    .out_addr_o    (outAddr),
    .out_instr_o   (outInstr),
    .full_o        (full),
    .err_illegal_o (errIllegal)
  );

   // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts imem writes as seen on the handshake at each rising edge.
  always @(posedge clk) begin
    if (rst_n && outValid && outReady) nWrites++;
  end

  task automatic applyStimulus(input vec_t v, input logic valid);
    opcode  = v.opc;
    rd      = v.rd;
    rs1     = v.rs1;
    rs2     = v.rs2;
    funct3  = v.f3;
    funct7  = v.f7;
    imm     = v.imm;
    inValid = valid;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams vecs[base..base+n-1] back-to-back with out_ready high; addresses start at 0.
  task automatic runGroup(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(vecs[base + i], 1'b1);
      checkOutput($sformatf("in_ready before vec %0d", base + i), 32'(inReady), 32'd1);
      tick();
      checkOutput($sformatf("out_valid vec %0d", base + i), 32'(outValid), 32'd1);
      checkOutput($sformatf("out_instr vec %0d", base + i), outInstr, vecs[base + i].expWord);
      checkOutput($sformatf("out_addr vec %0d", base + i), 32'(outAddr), 32'(i));
    end
  endtask

  initial begin
    nTests   = 0;
    nFail    = 0;
    nWrites  = 0;
    vecs[0] = '{7'b0010011, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 12'd7,    32'h00700013};
    vecs[1] = '{7'b0100011, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 12'd3584, 32'hE0000023};
    vecs[2] = '{7'b1100011, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 12'd1,    32'h00000163};
    vecs[3] = '{7'b1100011, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 12'd1024, 32'h000000E3};
    vecs[4] = '{7'b1100011, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 12'd2048, 32'h80000063};
    vecs[5] = '{7'b0110011, 5'd0,  5'd0,  5'd0,  3'd0, 7'h01, 12'd0,    32'h02000033};
    vecs[6] = '{7'b0010011, 5'd5,  5'd10, 5'd31, 3'd3, 7'h7F, 12'h123,  32'h12353293};
    vecs[7] = '{7'b0000011, 5'd2,  5'd1,  5'd0,  3'd2, 7'h00, 12'hFFF,  32'hFFF0A103};
    vecs[8] = '{7'b0100011, 5'd0,  5'd4,  5'd3,  3'd2, 7'h00, 12'h0AB,  32'h0A3225A3};
    vecs[9] = '{7'b0110011, 5'd4,  5'd6,  5'd7,  3'd5, 7'h20, 12'h000,  32'h40735233};
    illegalVec = '{7'b1111111, 5'd1, 5'd1, 5'd1, 3'd1, 7'h01, 12'd1, 32'h0};

    rst_n    = 1'b0;
    clear    = 1'b0;
    outReady = 1'b1;
    applyStimulus(vecs[0], 1'b0);
    #12;
    rst_n = 1'b1;

    checkOutput("reset in_ready", 32'(inReady), 32'd1);
    checkOutput("reset out_valid", 32'(outValid), 32'd0);
    checkOutput("reset out_addr", 32'(outAddr), 32'd0);
    checkOutput("reset out_instr", outInstr, 32'd0);
    checkOutput("reset full", 32'(full), 32'd0);
    checkOutput("reset err_illegal", 32'(errIllegal), 32'd0);

    tick();
    runGroup(0, 4);
    checkOutput("in_ready at depth", 32'(inReady), 32'd0);
    inValid = 1'b0;
    tick();
    checkOutput("full after drain", 32'(full), 32'd1);
    checkOutput("out_valid when full", 32'(outValid), 32'd0);
    checkOutput("writes group0", 32'(nWrites), 32'd4);

    applyStimulus(vecs[5], 1'b1);
    repeat (3) tick();
    checkOutput("full holds", 32'(full), 32'd1);
    checkOutput("in_ready full", 32'(inReady), 32'd0);
    checkOutput("out_valid ignored", 32'(outValid), 32'd0);
    checkOutput("writes while full", 32'(nWrites), 32'd4);

    clear = 1'b1;
    tick();
    clear   = 1'b0;
    inValid = 1'b0;
    checkOutput("clear full", 32'(full), 32'd0);
    checkOutput("clear out_valid", 32'(outValid), 32'd0);
    checkOutput("clear in_ready", 32'(inReady), 32'd1);

    runGroup(4, 2);
    applyStimulus(illegalVec, 1'b1);
    tick();
    checkOutput("illegal err", 32'(errIllegal), 32'd1);
    checkOutput("illegal out_valid", 32'(outValid), 32'd0);
    checkOutput("writes after illegal", 32'(nWrites), 32'd6);
    applyStimulus(vecs[6], 1'b1);
    tick();
    checkOutput("post-illegal instr", outInstr, vecs[6].expWord);
    checkOutput("post-illegal addr", 32'(outAddr), 32'd2);
    checkOutput("err sticky", 32'(errIllegal), 32'd1);

    applyStimulus(vecs[7], 1'b1);
    outReady = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("stall in_ready %0d", c), 32'(inReady), 32'd0);
      tick();
      checkOutput($sformatf("stall valid %0d", c), 32'(outValid), 32'd1);
      checkOutput($sformatf("stall instr %0d", c), outInstr, vecs[6].expWord);
      checkOutput($sformatf("stall addr %0d", c), 32'(outAddr), 32'd2);
    end
    checkOutput("writes during stall", 32'(nWrites), 32'd6);
    inValid  = 1'b0;
    outReady = 1'b1;
    tick();
    checkOutput("release out_valid", 32'(outValid), 32'd0);
    checkOutput("release single write", 32'(nWrites), 32'd7);

    applyStimulus(vecs[7], 1'b1);
    outReady = 1'b0;
    tick();
    inValid = 1'b0;
    checkOutput("pend before reset", 32'(outValid), 32'd1);
    checkOutput("pend addr before reset", 32'(outAddr), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset out_valid", 32'(outValid), 32'd0);
    checkOutput("async reset addr", 32'(outAddr), 32'd0);
    checkOutput("async reset instr", outInstr, 32'd0);
    checkOutput("async reset err", 32'(errIllegal), 32'd0);
    #3;
    rst_n    = 1'b1;
    outReady = 1'b1;
    tick();
    runGroup(8, 2);
    inValid = 1'b0;
    tick();
    checkOutput("final out_valid", 32'(outValid), 32'd0);
    checkOutput("final writes", 32'(nWrites), 32'd9);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
